// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared codes for the instruction-fetch sequencer.
//   - fetch fault codes carried alongside each buffered instruction
//   - fetch FSM state encodings (2-bit)
//   - the NOP word substituted for an instruction that could not be fetched
package if_fetch_pkg;

    // Fault code attached to the IF/ID buffer entry.
    localparam logic [1:0] FETCH_FAULT_NONE     = 2'd0;
    localparam logic [1:0] FETCH_FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FETCH_FAULT_ACCESS   = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Fetch sequencer states.
    //   FS_REQ   : ready to present pc to instruction memory
    //   FS_WAIT  : one request outstanding, waiting for its response
    //   FS_DRAIN : request outstanding but made stale by a redirect
    //   FS_FAULT : a faulting entry was produced; halted until redirect
    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_DRAIN = 2'd2,
        FS_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_buffer.sv
// if_buffer: single-entry IF/ID pipeline register.
//
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   load                  write a new entry this edge
//   flush                 discard the entry (wins over load)
//   consume               decode takes the entry this edge
//   load_instr/pc/fault   contents written on load
//   valid/instr/pc/fault  current entry
//   free                  entry can accept a load this edge (empty or being consumed)
//
// Priority on each edge: flush > load > consume. A load on the same edge as
// a consume replaces the old entry. Fields only change on an accepted load,
// so they are stable while the entry waits for decode.
module if_buffer
    import if_fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic            consume,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic [1:0]      load_fault,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [1:0]      fault,
    output logic            free
);

    assign free = !valid || consume;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
            fault <= FETCH_FAULT_NONE;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end else if (consume) begin
                valid <= 1'b0;
            end

            if (load && !flush) begin
                instr <= load_instr;
                pc    <= load_pc;
                fault <= load_fault;
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch sequencer between the PC register, instruction
// memory and decode.
//
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   pc                  current PC register value
//   pc_load             load strobe to the PC register (advance or redirect)
//   redirect            execute resolved a taken control transfer; the PC
//                       mux already selects the target
//   imem_req_*          request channel (valid/ready), address = pc
//   imem_resp_*         response channel, single-cycle pulse, no back-pressure
//   id_valid/instr/pc/fault, id_ready   IF/ID buffer towards decode
//   dbg_state           current fetch FSM state (fetch_state_t encoding)
//
// Handshake semantics: a request transfers on a clock edge where both
// imem_req_valid and imem_req_ready are high; imem_req_valid is never raised
// unless the request can be taken to completion (buffer space guaranteed),
// and it is not held across a redirect. The buffer entry transfers to decode
// on an edge where id_valid and id_ready are both high; the entry is held
// stable otherwise. The response channel has no ready: a response pulse is
// consumed or dropped in the cycle it appears.
//
// Exactly one request is ever outstanding. A request is only issued when the
// buffer will be free, so a response can always be captured.
module if_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_load,
    input  logic            redirect,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [1:0]      id_fault,
    input  logic            id_ready,
    output logic [1:0]      dbg_state
);

    import if_fetch_pkg::*;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] req_pc;

    logic            buf_free;
    logic            buf_load;
    logic [XLEN-1:0] buf_load_instr;
    logic [XLEN-1:0] buf_load_pc;
    logic [1:0]      buf_load_fault;

    logic            aligned;
    logic            req_valid;
    logic            req_fire;
    logic            advance;

    assign aligned       = (pc[1:0] == 2'b00);
    assign imem_req_addr = pc;
    assign dbg_state     = state;

    // Both strobes are forced low during reset so nothing leaves the block
    // while state is being reinitialised.
    assign imem_req_valid = req_valid && !reset;
    assign pc_load        = (advance || redirect) && !reset;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        req_valid      = 1'b0;
        req_fire       = 1'b0;
        advance        = 1'b0;
        buf_load       = 1'b0;
        buf_load_instr = imem_resp_data;
        buf_load_pc    = req_pc;
        buf_load_fault = FETCH_FAULT_NONE;

        case (state)
            FS_REQ: begin
                req_valid = buf_free && !redirect && aligned;
                // A redirect only reloads the PC; fetch resumes from the
                // target next cycle. A stray response here has no owner.
                if (!redirect && buf_free) begin
                    if (aligned) begin
                        if (imem_req_ready) begin
                            req_fire   = 1'b1;
                            state_next = FS_WAIT;
                        end
                    end else begin
                        // Misaligned pc never reaches memory; hand decode a
                        // NOP tagged with the fault instead.
                        buf_load       = 1'b1;
                        buf_load_instr = NOP_INSTR;
                        buf_load_pc    = pc;
                        buf_load_fault = FETCH_FAULT_MISALIGN;
                        state_next     = FS_FAULT;
                    end
                end
            end

            FS_WAIT: begin
                if (imem_resp_valid) begin
                    if (redirect) begin
                        // Redirect wins: the response belongs to the
                        // squashed path and is dropped.
                        state_next = FS_REQ;
                    end else begin
                        buf_load = 1'b1;
                        if (imem_resp_err) begin
                            // Keep pc on the faulting address.
                            buf_load_fault = FETCH_FAULT_ACCESS;
                            state_next     = FS_FAULT;
                        end else begin
                            advance    = 1'b1;
                            state_next = FS_REQ;
                        end
                    end
                end else if (redirect) begin
                    // Response still owed by memory; swallow it before
                    // issuing on the new path.
                    state_next = FS_DRAIN;
                end
            end

            FS_DRAIN: begin
                if (imem_resp_valid) begin
                    state_next = FS_REQ;
                end
            end

            FS_FAULT: begin
                if (redirect) begin
                    state_next = FS_REQ;
                end
            end

            default: begin
                state_next = FS_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and captured request pc
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= FS_REQ;
            req_pc <= '0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                req_pc <= pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // IF/ID buffer; a redirect flushes whatever it holds.
    // ------------------------------------------------------------------
    if_buffer #(
        .XLEN (XLEN)
    ) u_buffer (
        .clock      (clock),
        .reset      (reset),
        .load       (buf_load),
        .flush      (redirect),
        .consume    (id_ready),
        .load_instr (buf_load_instr),
        .load_pc    (buf_load_pc),
        .load_fault (buf_load_fault),
        .valid      (id_valid),
        .instr      (id_instr),
        .pc         (id_pc),
        .fault      (id_fault),
        .free       (buf_free)
    );

endmodule
